// File: rtl/alu_wb_buffer.sv
// Execute-to-writeback buffer: 2-entry FIFO for packed-SIMD ALU results that
// updates the Z/N/V flags and a saturation event counter on retirement.
module alu_wb_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_result,
    input  logic             in_ov_hi,
    input  logic             in_ov_lo,
    input  logic [3:0]       in_rd,
    input  logic             in_we,
    input  logic             in_flag_en,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [3:0]       out_rd,
    output logic             out_we,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_clr
);

    localparam int unsigned RES_W = 16;
    localparam int unsigned RD_W  = 4;
    localparam int unsigned CW    = 2;

    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             ov_hi;
        logic             ov_lo;
        logic [RD_W-1:0]  rd;
        logic             we;
        logic             flag_en;
    } entry_t;

    entry_t           mem_q [2];
    entry_t           mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_we_q, out_we_d;
    logic [RES_W-1:0] out_result_q, out_result_d;
    logic [RD_W-1:0]  out_rd_q, out_rd_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_v_q, flag_v_d;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
    logic             push_c, pop_c, head_sat_c;

    assign push_c     = in_valid & in_ready_q & ~flush;
    assign pop_c      = out_valid_q & out_ready & ~flush;
    assign head_sat_c = mem_q[rd_ptr_q].ov_hi | mem_q[rd_ptr_q].ov_lo;

    // Next-state for storage, pointers, retirement side effects and the
    // registered view of the next head entry.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        flag_v_d  = flag_v_q;
        sat_cnt_d = sat_cnt_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = '{result: in_result, ov_hi: in_ov_hi, ov_lo: in_ov_lo,
                                rd: in_rd, we: in_we, flag_en: in_flag_en};
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            count_d  = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end

        if (pop_c && mem_q[rd_ptr_q].flag_en) begin
            flag_z_d = (mem_q[rd_ptr_q].result == RES_W'(0));
            flag_n_d = mem_q[rd_ptr_q].result[RES_W-1];
            flag_v_d = head_sat_c;
        end

        // Clear wins over a same-cycle increment; the counter sticks at max.
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (pop_c && head_sat_c && (sat_cnt_q != {CNT_W{1'b1}})) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end

        out_valid_d  = (count_d != CW'(0));
        in_ready_d   = (count_d != CW'(DEPTH));
        out_result_d = mem_d[rd_ptr_d].result;
        out_rd_d     = mem_d[rd_ptr_d].rd;
        out_we_d     = out_valid_d & mem_d[rd_ptr_d].we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_we_q     <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            flag_z_q     <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_v_q     <= 1'b0;
            sat_cnt_q    <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_we_q     <= out_we_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            flag_z_q     <= flag_z_d;
            flag_n_q     <= flag_n_d;
            flag_v_q     <= flag_v_d;
            sat_cnt_q    <= sat_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_we     = out_we_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign flag_z     = flag_z_q;
    assign flag_n     = flag_n_q;
    assign flag_v     = flag_v_q;
    assign sat_cnt    = sat_cnt_q;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Self-checking bench for alu_wb_buffer: scoreboard on the output stream plus
// a flag/counter vector table and hand-written corner-case sequences.
module tb_alu_wb_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_result;
    logic        in_ov_hi, in_ov_lo;
    logic [3:0]  in_rd;
    logic        in_we, in_flag_en;
    logic        flush;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_rd;
    logic        out_we;
    logic        flag_z, flag_n, flag_v;
    logic [7:0]  sat_cnt;
    logic        sat_clr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  rd;
        logic        we;
    } item_t;

    typedef struct {
        logic [15:0] res;
        logic        ovh, ovl, fen;
        logic        z, n, v;
    } vec_t;

    item_t sb[$];
    vec_t  vt[7];

    alu_wb_buffer #(.DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_ov_hi(in_ov_hi), .in_ov_lo(in_ov_lo), .in_rd(in_rd), .in_we(in_we),
        .in_flag_en(in_flag_en), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic ovh,
                         input logic ovl, input logic [3:0] rd, input logic fen);
        in_valid   = v;
        in_result  = r;
        in_ov_hi   = ovh;
        in_ov_lo   = ovl;
        in_rd      = rd;
        in_we      = 1'b1;
        in_flag_en = fen;
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_we", 32'(out_we), 32'd0);
        check("rst_out_result", 32'(out_result), 32'h0);
        check("rst_out_rd", 32'(out_rd), 32'h0);
        check("rst_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    endtask

    // Scoreboard: retire on accepted pop, enqueue on accepted push.
    always @(negedge clk) begin
        item_t it;
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_pop: got result %h with nothing expected", out_result);
                end else begin
                    it = sb.pop_front();
                    check("sb_result", 32'(out_result), 32'(it.res));
                    check("sb_rd", 32'(out_rd), 32'(it.rd));
                    check("sb_we", 32'(out_we), 32'(it.we));
                end
            end
            if (in_valid && in_ready) begin
                it.res = in_result;
                it.rd  = in_rd;
                it.we  = in_we;
                sb.push_back(it);
            end
        end
    end

    initial begin
        int sat_exp;

        vt[0] = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1] = '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2] = '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[3] = '{16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[4] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[5] = '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[6] = '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        flush = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
        repeat (3) cyc();
        check_reset_vals();
        rst_n = 1'b1;
        cyc();

        // Single pass with both lanes saturated.
        out_ready = 1'b1;
        drive(1'b1, 16'h7F80, 1'b1, 1'b1, 4'd3, 1'b1);
        cyc();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_result", 32'(out_result), 32'h7F80);
        check("t1_out_rd", 32'(out_rd), 32'd3);
        cyc();
        check("t1_flags", {29'd0, flag_z, flag_n, flag_v}, 32'b001);
        check("t1_sat_cnt", 32'(sat_cnt), 32'd1);
        check("t1_empty", 32'(out_valid), 32'd0);

        // Backpressure until full, then drain.
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 4'd1, 1'b1);
        cyc();
        drive(1'b1, 16'h0002, 1'b0, 1'b0, 4'd2, 1'b1);
        cyc();
        check("t2_full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 16'h0003, 1'b0, 1'b0, 4'd3, 1'b1);
        cyc();
        in_valid = 1'b0;
        check("t2_hold_result", 32'(out_result), 32'h0001);
        out_ready = 1'b1;
        cyc();
        check("t2_second", 32'(out_result), 32'h0002);
        check("t2_second_valid", 32'(out_valid), 32'd1);
        cyc();
        check("t2_drained_valid", 32'(out_valid), 32'd0);
        check("t2_drained_ready", 32'(in_ready), 32'd1);
        check("t2_flags", {29'd0, flag_z, flag_n, flag_v}, 32'b000);

        // Streaming at count 1: push and pop every cycle.
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 4'd4, 1'b1);
        cyc();
        check("t3_r0", 32'(out_result), 32'h0010);
        drive(1'b1, 16'h0020, 1'b0, 1'b0, 4'd5, 1'b1);
        cyc();
        check("t3_r1", 32'(out_result), 32'h0020);
        check("t3_r1_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 16'h0030, 1'b0, 1'b0, 4'd6, 1'b1);
        cyc();
        check("t3_r2", 32'(out_result), 32'h0030);
        check("t3_r2_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        cyc();
        check("t3_empty", 32'(out_valid), 32'd0);

        // Flush beats both a push and a pop in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 16'h0AAA, 1'b1, 1'b1, 4'd7, 1'b1);
        cyc();
        drive(1'b1, 16'h8BBB, 1'b1, 1'b0, 4'd8, 1'b1);
        cyc();
        check("t4_full", 32'(in_ready), 32'd0);
        drive(1'b1, 16'h0CCC, 1'b0, 1'b1, 4'd9, 1'b1);
        out_ready = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_in_ready", 32'(in_ready), 32'd1);
        check("t4_flags", {29'd0, flag_z, flag_n, flag_v}, 32'b000);
        check("t4_sat_cnt", 32'(sat_cnt), 32'd1);
        repeat (2) cyc();
        check("t4_still_empty", 32'(out_valid), 32'd0);

        // Flag/counter vector table, one op at a time.
        sat_exp = 1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vt[i].res, vt[i].ovh, vt[i].ovl, 4'(i), vt[i].fen);
            cyc();
            in_valid = 1'b0;
            cyc();
            if (vt[i].ovh || vt[i].ovl) sat_exp++;
            check($sformatf("vec%0d_flags", i), {29'd0, flag_z, flag_n, flag_v},
                  {29'd0, vt[i].z, vt[i].n, vt[i].v});
            check($sformatf("vec%0d_sat", i), 32'(sat_cnt), 32'(sat_exp));
        end

        // 300 saturating retirements: counter must stick at 255.
        drive(1'b1, 16'h4000, 1'b1, 1'b0, 4'd1, 1'b1);
        repeat (300) cyc();
        in_valid = 1'b0;
        repeat (2) cyc();
        check("t6_sat_max", 32'(sat_cnt), 32'd255);

        // Clear coincident with a saturating pop.
        out_ready = 1'b0;
        drive(1'b1, 16'h0100, 1'b0, 1'b1, 4'd2, 1'b1);
        cyc();
        in_valid = 1'b0;
        out_ready = 1'b1;
        sat_clr = 1'b1;
        cyc();
        sat_clr = 1'b0;
        check("t6_clr", 32'(sat_cnt), 32'd0);
        drive(1'b1, 16'h0200, 1'b1, 1'b0, 4'd3, 1'b1);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("t6_after_clr", 32'(sat_cnt), 32'd1);
        check("t6_flag_v", 32'(flag_v), 32'd1);

        // Asynchronous reset while entries are buffered.
        out_ready = 1'b0;
        drive(1'b1, 16'hCAFE, 1'b1, 1'b1, 4'd9, 1'b1);
        cyc();
        drive(1'b1, 16'hBEEF, 1'b0, 1'b0, 4'd10, 1'b1);
        cyc();
        in_valid = 1'b0;
        check("t7_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        check("t7_post_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_wb_buffer.md
# alu_wb_buffer

Execute-to-writeback buffer that consumes the packed-SIMD ALU result (16-bit result plus per-byte-lane saturation indicators) and holds it in a 2-entry FIFO under a valid/ready handshake. On retirement it updates the architectural condition flags (Z, N, V) and a saturation event counter. It sits directly downstream of the ALU datapath and directly upstream of the register-file write port.

## Interface
- DEPTH, 2, FIFO entries; fixed at 2, other values unsupported.
- CNT_W, 8, width of the saturation event counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  buffer can accept; equals !full, registered.
- in_result  in  16  ALU result, hi byte [15:8], lo byte [7:0].
- in_ov_hi  in  1  hi byte lane saturated.
- in_ov_lo  in  1  lo byte lane saturated.
- in_rd  in  4  destination register index.
- in_we  in  1  register write enable.
- in_flag_en  in  1  this op updates Z/N/V.
- flush  in  1  synchronous pipeline flush.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback consumes head.
- out_result  out  16  head result.
- out_rd  out  4  head destination.
- out_we  out  1  head write enable, gated by out_valid.
- flag_z, flag_n, flag_v  out  1 each  architectural flags.
- sat_cnt  out  CNT_W  count of retired saturating ops.
- sat_clr  in  1  synchronous clear of sat_cnt.

## Operation
- Push = in_valid & in_ready & !flush. Pop = out_valid & out_ready & !flush.
- FIFO: 2 entries, each holding {result, ov_hi, ov_lo, rd, we, flag_en}. 1-bit read and write pointers wrap 1→0. 2-bit count ranges 0..2.
- Push at count 2 cannot occur because in_ready is 0. Push and pop in the same cycle leave count unchanged and advance both pointers.
- Empty: out_valid=0 and out_we=0. out_result/out_rd still show stale head contents; consumers ignore them.
- Flush: count ← 0 and pointers ← 0. Takes priority over a same-cycle push (incoming dropped) and pop (nothing retires). Flags and sat_cnt are not changed by a flush.
- Retire (on pop of head entry), when head flag_en=1:
  - flag_z ← (result==16'h0000)
  - flag_n ← result[15]
  - flag_v ← ov_hi | ov_lo
  - When flag_en=0, flags hold.
- sat_cnt: increments by 1 on pop when head ov_hi|ov_lo, independent of flag_en. It saturates at 2^CNT_W−1 and does not wrap. sat_clr takes priority over a same-cycle increment and clears to 0.
- Reset, asynchronous: count=0, pointers=0, out_valid=0, in_ready=1, out_we=0, out_result=0, out_rd=0, flag_z=0, flag_n=0, flag_v=0, sat_cnt=0. Storage contents are don't-care but read as 0 after reset. Reset asserted mid-transfer discards all entries immediately.

## Timing
- Latency: data pushed in cycle t is visible on out_* with out_valid=1 in cycle t+1 (registered).
- Throughput: 1 push and 1 pop per cycle sustained. A full buffer with out_ready held high drains 1 entry per cycle.
- in_ready depends only on registered count; no combinational path from out_ready to in_ready.
- Flag and sat_cnt updates from a pop at cycle t are visible at t+1.
- out_* hold stable while out_valid=1 and out_ready=0.

## Test plan
- Reset/single pass: release rst_n, push result=16'h7F80 with ov_hi=1, ov_lo=1, rd=3, we=1, flag_en=1, out_ready=1.
  - Next cycle: out_valid=1, out_result=7F80, out_rd=3.
  - After pop: flag_z=0, flag_n=0, flag_v=1, sat_cnt=1.
- Backpressure/full: out_ready=0, push 16'h0001 then 16'h0002.
  - in_ready=0 after the 2nd push; a 3rd push attempt is ignored.
  - Raise out_ready: pops 0001 then 0002 in consecutive cycles, then out_valid=0 and in_ready=1.
- Simultaneous push/pop at count 1: in order, stream 0x0010, 0x0020, 0x0030 with out_ready=1 every cycle. Count stays 1 and results emerge in order one cycle after each push.
- Flush priority: buffer holding 2 entries, assert flush with in_valid=1 and out_ready=1.
  - Next cycle: out_valid=0 and in_ready=1.
  - Flags and sat_cnt unchanged; flushed data never appears.
- Flags with flag_en: pop result 16'h0000 with flag_en=1, giving Z=1, N=0, V=0. Then pop 16'h8000 with flag_en=0 and ov_lo=1: flags remain Z=1, N=0, V=0, and sat_cnt increments.
- Counter saturation/clear: retire 300 saturating ops, giving sat_cnt=255 (no wrap). Assert sat_clr together with a saturating pop: sat_cnt=0. Assert rst_n low mid-stream: all outputs return to reset values asynchronously.
